// File: rtl/mac_r_pkg.sv
// rtl/mac_r_pkg.sv - shared types, CRC constants and descriptor layout for the MII receive MAC
package mac_r_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_STAT = 3'd4,
    ST_SKIP = 3'd5
  } state_e;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int DESC_CRC_ERR = 15;
  localparam int DESC_LEN_ERR = 14;
  localparam int DESC_RX_ER   = 13;
  localparam int DESC_ALIGN   = 12;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_r_crc32.sv
// rtl/mac_r_crc32.sv - byte-wide reflected CRC-32 register, no final inversion
module mac_r_crc32
  import mac_r_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        calc_en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (calc_en) begin
      crc <= crc32_byte(crc, din);
    end
  end

endmodule

// File: rtl/mac_r.sv
// rtl/mac_r.sv - MII receive MAC: preamble strip, byte assembly, FCS/length check, FIFO writes
module mac_r
  import mac_r_pkg::*;
#(
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int FIFO_THRESH = 2566,
  parameter int DELAY       = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rx_d,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_dout,
  input  logic [11:0] data_fifo_depth,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_full,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0] MIN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_C = 11'(MAX_LEN);
  localparam logic [11:0] THR_C = 12'(FIFO_THRESH);

  // DELAY only matters to zero-delay-averse simulators; the RTL uses plain NBAs.
  if (DELAY < 0) begin : g_delay_unused
  end

  logic        dv_q, er_q;
  logic [3:0]  d_q;
  state_e      state;
  logic [3:0]  lo_nib;
  logic        odd;
  logic [10:0] cnt;
  logic        over, er_seen;
  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic [15:0] desc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dv_q <= 1'b0;
      er_q <= 1'b0;
      d_q  <= 4'h0;
    end else begin
      dv_q <= rx_dv;
      er_q <= rx_er;
      d_q  <= rx_d;
    end
  end

  assign crc_init = (state == ST_PRE) && dv_q && (d_q == 4'hD);
  assign crc_en   = (state == ST_DATA) && dv_q && odd;

  mac_r_crc32 u_crc (
    .clk     (clk),
    .rstn    (rstn),
    .init    (crc_init),
    .calc_en (crc_en),
    .din     ({d_q, lo_nib}),
    .crc     (crc)
  );

  always_comb begin
    desc = {5'b0, cnt};
    desc[DESC_CRC_ERR] = (crc != CRC_RESIDUE);
    desc[DESC_LEN_ERR] = over || (cnt < MIN_C);
    desc[DESC_RX_ER]   = er_seen;
    desc[DESC_ALIGN]   = odd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      lo_nib         <= 4'h0;
      odd            <= 1'b0;
      cnt            <= 11'd0;
      over           <= 1'b0;
      er_seen        <= 1'b0;
      data_fifo_wr   <= 1'b0;
      data_fifo_dout <= 8'h00;
      ptr_fifo_wr    <= 1'b0;
      ptr_fifo_dout  <= 16'h0000;
      drop_cnt       <= 16'h0000;
    end else begin
      data_fifo_wr <= 1'b0;
      ptr_fifo_wr  <= 1'b0;
      case (state)
        ST_IDLE: if (dv_q) state <= (d_q == 4'h5) ? ST_PRE : ST_SKIP;
        ST_PRE: begin
          if (!dv_q) begin
            state <= ST_IDLE;
          end else if (d_q == 4'hD) begin
            // Space is only judged here; the threshold leaves room for a maximum frame.
            if (ptr_fifo_full || (data_fifo_depth > THR_C)) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              state <= ST_SKIP;
            end else begin
              odd     <= 1'b0;
              cnt     <= 11'd0;
              over    <= 1'b0;
              er_seen <= 1'b0;
              state   <= ST_DATA;
            end
          end else if (d_q != 4'h5) begin
            state <= ST_SKIP;
          end
        end
        ST_DATA: begin
          if (!dv_q) begin
            state <= ST_CHK;
          end else begin
            if (er_q) er_seen <= 1'b1;
            odd <= ~odd;
            if (!odd) begin
              lo_nib <= d_q;
            end else if (cnt < MAX_C) begin
              data_fifo_wr   <= 1'b1;
              data_fifo_dout <= {d_q, lo_nib};
              cnt            <= cnt + 11'd1;
            end else begin
              over <= 1'b1;
            end
          end
        end
        ST_CHK: begin
          ptr_fifo_wr   <= 1'b1;
          ptr_fifo_dout <= desc;
          state         <= ST_STAT;
        end
        ST_STAT: state <= ST_IDLE;
        ST_SKIP: if (!dv_q) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_r.sv
// tb/tb_mac_r.sv - directed frames against a frame-level model of the receive MAC
module tb_mac_r;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [3:0]  rx_d = 4'h0;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_dout;
  logic [11:0] data_fifo_depth = 12'd0;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_full = 1'b0;
  logic [15:0] drop_cnt;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_drop = 0;
  logic        prev_wr = 1'b0;
  logic [15:0] last_desc = 16'h0;
  logic [7:0]  frame[$];
  exp_t        exp_b[$];
  exp_t        exp_d[$];

  mac_r dut (
    .clk             (clk),
    .rstn            (rstn),
    .rx_dv           (rx_dv),
    .rx_er           (rx_er),
    .rx_d            (rx_d),
    .data_fifo_wr    (data_fifo_wr),
    .data_fifo_dout  (data_fifo_dout),
    .data_fifo_depth (data_fifo_depth),
    .ptr_fifo_wr     (ptr_fifo_wr),
    .ptr_fifo_dout   (ptr_fifo_dout),
    .ptr_fifo_full   (ptr_fifo_full),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Standard Ethernet CRC-32 (final inversion applied) over frame[0 .. n-1].
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [15:0] model_desc(input bit extra, input bit er);
    int          n;
    logic [31:0] fcs;
    bit          crc_bad, len_bad;
    n = frame.size();
    fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
    crc_bad = (fcs != fcs_of(n - 4));
    len_bad = (n < 64) || (n > 1518);
    return {crc_bad, len_bad, er, extra, 1'b0, 11'((n > 1518) ? 1518 : n)};
  endfunction

  task automatic build(input int ndata, input bit good_fcs, input int seed);
    logic [31:0] f;
    frame.delete();
    for (int i = 0; i < ndata; i++) frame.push_back(8'(i * 7 + seed));
    if (good_fcs) begin
      f = fcs_of(ndata);
      frame.push_back(f[7:0]);
      frame.push_back(f[15:8]);
      frame.push_back(f[23:16]);
      frame.push_back(f[31:24]);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (exp_b.size() > 0 && exp_b[0].due == cyc) begin
        chk("byte_wr", data_fifo_wr, 1);
        chk("byte_val", data_fifo_dout, exp_b[0].val);
        void'(exp_b.pop_front());
      end else if (data_fifo_wr) begin
        chk("byte_unexpected", data_fifo_wr, 0);
      end
      if (data_fifo_wr) chk("byte_back_to_back", prev_wr, 0);
      if (exp_d.size() > 0 && exp_d[0].due == cyc) begin
        chk("desc_wr", ptr_fifo_wr, 1);
        chk("desc_val", ptr_fifo_dout, exp_d[0].val);
        last_desc = ptr_fifo_dout;
        void'(exp_d.pop_front());
      end else if (ptr_fifo_wr) begin
        chk("desc_unexpected", ptr_fifo_wr, 0);
      end
    end
    prev_wr = data_fifo_wr;
  end

  task automatic nib(input logic [3:0] n, input logic er);
    rx_dv = 1'b1;
    rx_d  = n;
    rx_er = er;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_d  = 4'h0;
    #1;
    chk("rst_data_wr", data_fifo_wr, 0);
    chk("rst_data_dout", data_fifo_dout, 0);
    chk("rst_ptr_wr", ptr_fifo_wr, 0);
    chk("rst_ptr_dout", ptr_fifo_dout, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    exp_b.delete();
    exp_d.delete();
    exp_drop = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] depth, input logic full, input bit extra,
                      input int er_nib, input int abort_nib);
    bit          acc;
    int          nn;
    logic [15:0] desc;
    exp_t        e;
    acc  = !full && (depth <= 12'd2566);
    desc = model_desc(extra, er_nib >= 0);
    data_fifo_depth = depth;
    ptr_fifo_full   = full;
    nn = 0;
    repeat (15) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < frame.size(); i++) begin
      for (int h = 0; h < 2; h++) begin
        if (abort_nib == nn) begin
          do_reset();
          return;
        end
        if (h == 1 && acc && i < 1518) begin
          e.due = cyc + 2;
          e.val = {8'h00, frame[i]};
          exp_b.push_back(e);
        end
        nib((h == 1) ? frame[i][7:4] : frame[i][3:0], nn == er_nib);
        nn++;
      end
    end
    if (extra) nib(4'hA, nn == er_nib);
    if (acc) begin
      e.due = cyc + 3;
      e.val = desc;
      exp_d.push_back(e);
    end else begin
      exp_drop++;
    end
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_d  = 4'h0;
    repeat (30) @(negedge clk);
    chk("queues_drained", exp_b.size() + exp_d.size(), 0);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data_wr", data_fifo_wr, 0);
    chk("reset_ptr_wr", ptr_fifo_wr, 0);
    chk("reset_ptr_dout", ptr_fifo_dout, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    build(60, 1'b1, 3);
    chk("model_pin_good64", model_desc(1'b0, 1'b0), 16'h0040);
    send(12'd0, 1'b0, 1'b0, -1, -1);
    chk("pin_good64", last_desc, 16'h0040);

    frame[62] = frame[62] ^ 8'h01;
    send(12'd0, 1'b0, 1'b0, -1, -1);
    chk("pin_badfcs64", last_desc, 16'h8040);

    build(36, 1'b1, 11);
    send(12'd0, 1'b0, 1'b0, -1, -1);
    chk("pin_short40", last_desc, 16'h4028);

    build(1600, 1'b0, 5);
    send(12'd0, 1'b0, 1'b0, -1, -1);
    chk("pin_long1600", last_desc, 16'hC5EE);

    build(60, 1'b1, 21);
    send(12'd2600, 1'b0, 1'b0, -1, -1);
    chk("drop_after_depth", drop_cnt, 1);
    send(12'd100, 1'b0, 1'b0, -1, -1);
    chk("pin_after_drop", last_desc, 16'h0040);

    send(12'd0, 1'b1, 1'b0, -1, -1);
    chk("drop_after_full", drop_cnt, 2);

    build(60, 1'b1, 9);
    chk("model_pin_er_align", model_desc(1'b1, 1'b1), 16'h3040);
    send(12'd0, 1'b0, 1'b1, 50, -1);
    chk("pin_er_align", last_desc, 16'h3040);

    send(12'd0, 1'b0, 1'b0, -1, 60);
    build(60, 1'b1, 33);
    send(12'd0, 1'b0, 1'b0, -1, -1);
    chk("pin_after_reset", last_desc, 16'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
